secuenciador_operandos_alu: RTL and testbench

//  Upstream/downstream wrapper stage for the combinational ALU on the lab board.

---
 rtl/secuenciador_operandos_alu.sv | 196 +++++++++++++++++++
 tb/tb_secuenciador_operandos_alu.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_operandos_alu.sv
// secuenciador_operandos_alu
// Sequencer stage for the lab-board ALU. Operand A, operand B and the opcode
// are loaded one at a time from the switches with a single push-button. The
// loaded values drive the ALU for one execute cycle, and the ALU result and
// flags are then frozen in holding registers for display.
//
// Optional build macro: SECUENCIADOR_CONTADOR_OPS_EN
//   When defined, adds output ops_total[7:0], a saturating count of completed
//   operations (EJECUTA->MUESTRA transitions). When undefined, the port and
//   the counter are absent.
module secuenciador_operandos_alu #(
    parameter int         N      = 4,
    parameter logic [3:0] OP_MAX = 4'd11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] dato_in,
    input  logic         boton_cargar,
    output logic [N-1:0] entrada1,
    output logic [N-1:0] entrada2,
    output logic [3:0]   selector,
    output logic         valido,
    input  logic [3:0]   resultado_alu,
    input  logic [3:0]   flags_alu,
    output logic [3:0]   resultado_reg,
    output logic [3:0]   banderas_reg,
    output logic         listo,
    output logic         error_op,
    output logic [2:0]   estado
`ifdef SECUENCIADOR_CONTADOR_OPS_EN
    ,
    output logic [7:0]   ops_total
`endif
);

    typedef enum logic [2:0] {
        CARGA_A  = 3'd0,
        CARGA_B  = 3'd1,
        CARGA_OP = 3'd2,
        EJECUTA  = 3'd3,
        MUESTRA  = 3'd4
    } estado_t;

    estado_t estado_r;
    estado_t estado_sig_s;

    logic sinc1_r;
    logic sinc2_r;
    logic previo_r;
    logic pulso_s;
    logic op_legal_s;

    logic carga_a_s;
    logic carga_b_s;
    logic carga_op_s;
    logic op_ilegal_s;
    logic captura_s;

    // The first synchronizer stage is used only to qualify the edge: a button
    // level that was not seen on two consecutive clocks (bounce) never pulses.
    assign pulso_s    = sinc1_r & sinc2_r & ~previo_r;
    assign op_legal_s = (dato_in[3:0] != 4'd0) && (dato_in[3:0] <= OP_MAX);
    assign estado     = estado_r;

    // Button synchronizer and edge-history flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sinc1_r  <= 1'b0;
            sinc2_r  <= 1'b0;
            previo_r <= 1'b0;
        end else begin
            sinc1_r  <= boton_cargar;
            sinc2_r  <= sinc1_r;
            previo_r <= sinc2_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_r <= CARGA_A;
        end else begin
            estado_r <= estado_sig_s;
        end
    end

    // Next-state logic and per-register load enables.
    always_comb begin
        estado_sig_s = estado_r;
        carga_a_s    = 1'b0;
        carga_b_s    = 1'b0;
        carga_op_s   = 1'b0;
        op_ilegal_s  = 1'b0;
        captura_s    = 1'b0;
        case (estado_r)
            CARGA_A: begin
                if (pulso_s) begin
                    carga_a_s    = 1'b1;
                    estado_sig_s = CARGA_B;
                end else begin
                    estado_sig_s = CARGA_A;
                end
            end
            CARGA_B: begin
                if (pulso_s) begin
                    carga_b_s    = 1'b1;
                    estado_sig_s = CARGA_OP;
                end else begin
                    estado_sig_s = CARGA_B;
                end
            end
            CARGA_OP: begin
                if (pulso_s && op_legal_s) begin
                    carga_op_s   = 1'b1;
                    estado_sig_s = EJECUTA;
                end else if (pulso_s) begin
                    op_ilegal_s  = 1'b1;
                    estado_sig_s = CARGA_OP;
                end else begin
                    estado_sig_s = CARGA_OP;
                end
            end
            EJECUTA: begin
                captura_s    = 1'b1;
                estado_sig_s = MUESTRA;
            end
            MUESTRA: begin
                if (pulso_s) begin
                    estado_sig_s = CARGA_A;
                end else begin
                    estado_sig_s = MUESTRA;
                end
            end
            default: begin
                estado_sig_s = CARGA_A;
            end
        endcase
    end

    // Operand/opcode registers: each changes only on its own load edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entrada1 <= '0;
            entrada2 <= '0;
            selector <= 4'd0;
            error_op <= 1'b0;
        end else begin
            if (carga_a_s) begin
                entrada1 <= dato_in;
            end
            if (carga_b_s) begin
                entrada2 <= dato_in;
            end
            if (carga_op_s) begin
                selector <= dato_in[3:0];
                error_op <= 1'b0;
            end else if (op_ilegal_s) begin
                error_op <= 1'b1;
            end
        end
    end

    // Result/flag capture at the closing edge of EJECUTA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resultado_reg <= 4'd0;
            banderas_reg  <= 4'd0;
        end else if (captura_s) begin
            resultado_reg <= resultado_alu;
            banderas_reg  <= flags_alu;
        end
    end

    // Registered status strobes, decoded from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valido <= 1'b0;
            listo  <= 1'b0;
        end else begin
            valido <= (estado_sig_s == EJECUTA);
            listo  <= (estado_sig_s == MUESTRA);
        end
    end

`ifdef SECUENCIADOR_CONTADOR_OPS_EN
    // Saturating count of completed operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_total <= 8'd0;
        end else if (captura_s && (ops_total != 8'hFF)) begin
            ops_total <= ops_total + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_secuenciador_operandos_alu.sv
// Self-checking bench for secuenciador_operandos_alu: directed table, corner
// sequences and randomized button/switch activity against a behavioural model.
// Honours SECUENCIADOR_CONTADOR_OPS_EN when the build defines it.
module tb_secuenciador_operandos_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dato_in;
    logic       boton_cargar;
    logic [3:0] entrada1;
    logic [3:0] entrada2;
    logic [3:0] selector;
    logic       valido;
    logic [3:0] resultado_alu;
    logic [3:0] flags_alu;
    logic [3:0] resultado_reg;
    logic [3:0] banderas_reg;
    logic       listo;
    logic       error_op;
    logic [2:0] estado;
`ifdef SECUENCIADOR_CONTADOR_OPS_EN
    logic [7:0] ops_total;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    secuenciador_operandos_alu dut (
        .clk           (clk),
        .rst           (rst),
        .dato_in       (dato_in),
        .boton_cargar  (boton_cargar),
        .entrada1      (entrada1),
        .entrada2      (entrada2),
        .selector      (selector),
        .valido        (valido),
        .resultado_alu (resultado_alu),
        .flags_alu     (flags_alu),
        .resultado_reg (resultado_reg),
        .banderas_reg  (banderas_reg),
        .listo         (listo),
        .error_op      (error_op),
        .estado        (estado)
`ifdef SECUENCIADOR_CONTADOR_OPS_EN
        ,
        .ops_total     (ops_total)
`endif
    );

    always #5 clk = ~clk;

    // Toy ALU seen by the DUT: arbitrary but deterministic.
    function automatic logic [3:0] alu_res(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        return a + b + op - 4'd1;
    endfunction
    function automatic logic [3:0] alu_flg(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        return b & op & ~a;
    endfunction

    assign resultado_alu = alu_res(entrada1, entrada2, selector);
    assign flags_alu     = alu_flg(entrada1, entrada2, selector);

    // ---------------- behavioural reference model ----------------
    int         m_fase;          // 0 A, 1 B, 2 OP, 3 execute, 4 display
    logic [3:0] m_a, m_b, m_op, m_res, m_flg;
    logic       m_err;
    int         m_cnt;
    logic       h1, h2, h3;      // button level seen at the last three clocks

    task automatic model_reset();
        m_fase = 0; m_a = 4'd0; m_b = 4'd0; m_op = 4'd0;
        m_res = 4'd0; m_flg = 4'd0; m_err = 1'b0; m_cnt = 0;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    endtask

    task automatic model_edge(input logic b, input logic [3:0] d);
        logic pulse;
        pulse = h1 & h2 & ~h3;    // held on two consecutive clocks, low before
        h3 = h2; h2 = h1; h1 = b;
        case (m_fase)
            0: if (pulse) begin m_a = d; m_fase = 1; end
            1: if (pulse) begin m_b = d; m_fase = 2; end
            2: if (pulse) begin
                   if (d >= 4'd1 && d <= 4'd11) begin m_op = d; m_err = 1'b0; m_fase = 3; end
                   else m_err = 1'b1;
               end
            3: begin
                   m_res = alu_res(m_a, m_b, m_op);
                   m_flg = alu_flg(m_a, m_b, m_op);
                   if (m_cnt < 255) m_cnt = m_cnt + 1;
                   m_fase = 4;
               end
            default: if (pulse) m_fase = 0;
        endcase
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("estado", int'(estado), m_fase);
        chk("entrada1", int'(entrada1), int'(m_a));
        chk("entrada2", int'(entrada2), int'(m_b));
        chk("selector", int'(selector), int'(m_op));
        chk("valido", int'(valido), (m_fase == 3) ? 1 : 0);
        chk("listo", int'(listo), (m_fase == 4) ? 1 : 0);
        chk("resultado_reg", int'(resultado_reg), int'(m_res));
        chk("banderas_reg", int'(banderas_reg), int'(m_flg));
        chk("error_op", int'(error_op), int'(m_err));
`ifdef SECUENCIADOR_CONTADOR_OPS_EN
        chk("ops_total", int'(ops_total), m_cnt);
`endif
    endtask

    // Apply inputs at the falling edge, clock, then compare at the next falling edge.
    task automatic tick(input logic b, input logic [3:0] d);
        boton_cargar = b;
        dato_in      = d;
        @(posedge clk);
        model_edge(b, d);
        @(negedge clk);
        compare_model();
    endtask

    task automatic press(input logic [3:0] d);
        for (int i = 0; i < 3; i++) tick(1'b1, d);
        for (int i = 0; i < 2; i++) tick(1'b0, d);
    endtask

    // Async reset mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset();
        boton_cargar = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       btn;
        logic [3:0] dato;
        logic [2:0] est;
        logic       val;
        logic       lis;
        logic [3:0] res;
        logic [3:0] flg;
    } vec_t;

    vec_t tabla[15];
    logic [3:0] saved_res, saved_e1;

    initial begin
        // A=5, B=3, op=1 -> ALU gives 8 / 0000
        tabla[0]  = '{1'b1, 4'h5, 3'd0, 1'b0, 1'b0, 4'h0, 4'h0};
        tabla[1]  = '{1'b1, 4'h5, 3'd0, 1'b0, 1'b0, 4'h0, 4'h0};
        tabla[2]  = '{1'b1, 4'h5, 3'd1, 1'b0, 1'b0, 4'h0, 4'h0};
        tabla[3]  = '{1'b0, 4'h3, 3'd1, 1'b0, 1'b0, 4'h0, 4'h0};
        tabla[4]  = '{1'b0, 4'h3, 3'd1, 1'b0, 1'b0, 4'h0, 4'h0};
        tabla[5]  = '{1'b1, 4'h3, 3'd1, 1'b0, 1'b0, 4'h0, 4'h0};
        tabla[6]  = '{1'b1, 4'h3, 3'd1, 1'b0, 1'b0, 4'h0, 4'h0};
        tabla[7]  = '{1'b1, 4'h3, 3'd2, 1'b0, 1'b0, 4'h0, 4'h0};
        tabla[8]  = '{1'b0, 4'h1, 3'd2, 1'b0, 1'b0, 4'h0, 4'h0};
        tabla[9]  = '{1'b0, 4'h1, 3'd2, 1'b0, 1'b0, 4'h0, 4'h0};
        tabla[10] = '{1'b1, 4'h1, 3'd2, 1'b0, 1'b0, 4'h0, 4'h0};
        tabla[11] = '{1'b1, 4'h1, 3'd2, 1'b0, 1'b0, 4'h0, 4'h0};
        tabla[12] = '{1'b1, 4'h1, 3'd3, 1'b1, 1'b0, 4'h0, 4'h0};
        tabla[13] = '{1'b0, 4'h1, 3'd4, 1'b0, 1'b1, 4'h8, 4'h0};
        tabla[14] = '{1'b0, 4'h7, 3'd4, 1'b0, 1'b1, 4'h8, 4'h0};

        rst = 1'b1; boton_cargar = 1'b0; dato_in = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_model();
        rst = 1'b0;

        // Reset while in CARGA_B with A already loaded
        press(4'h3);
        chk("t1_loaded_a", int'(entrada1), 3);
        tick(1'b1, 4'h6);
        do_reset();
        chk("t1_entrada1", int'(entrada1), 0);
        chk("t1_estado", int'(estado), 0);

        // Full operation from the table
        for (int i = 0; i < 15; i++) begin
            tick(tabla[i].btn, tabla[i].dato);
            chk($sformatf("tab%0d_estado", i), int'(estado), int'(tabla[i].est));
            chk($sformatf("tab%0d_valido", i), int'(valido), int'(tabla[i].val));
            chk($sformatf("tab%0d_listo", i), int'(listo), int'(tabla[i].lis));
            chk($sformatf("tab%0d_res", i), int'(resultado_reg), int'(tabla[i].res));
            chk($sformatf("tab%0d_flg", i), int'(banderas_reg), int'(tabla[i].flg));
        end

        // Display state: switches and a bounce must not disturb anything
        saved_res = resultado_reg;
        saved_e1  = entrada1;
        for (int i = 0; i < 5; i++) tick(1'b0, 4'($urandom_range(0, 15)));
        tick(1'b1, 4'hA);
        for (int i = 0; i < 3; i++) tick(1'b0, 4'hA);
        chk("t5_estado", int'(estado), 4);
        chk("t5_res_frozen", int'(resultado_reg), int'(saved_res));
        chk("t5_e1_frozen", int'(entrada1), int'(saved_e1));

        // Illegal opcodes, then a legal one
        press(4'h0);
        press(4'h2);
        press(4'h9);
        press(4'h0);
        chk("t3_err_zero", int'(error_op), 1);
        chk("t3_stay_zero", int'(estado), 2);
        press(4'hC);
        chk("t3_err_c", int'(error_op), 1);
        chk("t3_sel_kept", int'(selector), 1);
        for (int i = 0; i < 3; i++) tick(1'b1, 4'h2);
        chk("t3_to_exec", int'(estado), 3);
        chk("t3_err_clr", int'(error_op), 0);
        tick(1'b0, 4'h2);
        chk("t3_listo", int'(listo), 1);

        // Button held for 20 cycles in CARGA_A: exactly one load
        press(4'h0);
        for (int i = 0; i < 20; i++) tick(1'b1, 4'h9);
        tick(1'b0, 4'h9);
        chk("t4_estado", int'(estado), 1);
        chk("t4_entrada1", int'(entrada1), 9);

        // Randomized activity with occasional asynchronous resets
        for (int k = 0; k < 400; k++) begin
            int hi, lo;
            logic [3:0] d;
            hi = $urandom_range(1, 4);
            lo = $urandom_range(1, 3);
            d  = 4'($urandom_range(0, 15));
            for (int i = 0; i < hi; i++) tick(1'b1, d);
            for (int i = 0; i < lo; i++) tick(1'b0, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 60) == 0) do_reset();
        end

`ifdef SECUENCIADOR_CONTADOR_OPS_EN
        // Counter saturation and illegal opcodes not counted
        do_reset();
        for (int k = 0; k < 260; k++) begin
            press(4'($urandom_range(0, 15)));
            press(4'($urandom_range(0, 15)));
            if (k % 7 == 0) press(4'hF);
            press(4'($urandom_range(1, 11)));
            press(4'h0);
        end
        chk("t6_sat", int'(ops_total), 255);
        press(4'h1);
        press(4'h2);
        press(4'h0);
        press(4'hD);
        chk("t6_illegal", int'(ops_total), 255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
